// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by the fetch top, its FIFOs and the imem bus interface.
package fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc_addr;
    } fetch_pair_t;
endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/grant/response bus.
// master = fetch unit, slave = instruction memory.
interface pc_fetch_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through FIFO with flush and occupancy count.
// Holds fetch tags and buffered {inst, pc} pairs.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/pc_fetch.sv
// Fetch front end: PC, credit-limited imem requests, response
// tagging and the registered {inst, pc} pair feeding IF/ID.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              stall_in,
    pc_fetch_if.master        imem,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc_addr,
    output logic              if_valid
);
    localparam int CW = $clog2(DEPTH) + 1;
    // Extra bit: a jump can land while older responses are still
    // being discarded, so the two populations add up.
    localparam int DW = CW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [DW-1:0]     r_discard;
    fetch_pair_t       r_out;
    logic              r_valid;

    logic [CW-1:0]     w_out_cnt;
    logic [CW-1:0]     w_buf_cnt;
    logic [CW:0]       w_used;
    logic              w_tag_full;
    logic              w_tag_empty;
    logic              w_buf_full;
    logic              w_buf_empty;
    logic [ADDR_W-1:0] w_tag;
    fetch_pair_t       w_resp;
    fetch_pair_t       w_buf_head;
    logic              w_req;
    logic              w_grant;
    logic              w_drop;
    logic              w_accept;
    logic              w_bypass;
    logic              w_buf_push;
    logic              w_buf_pop;

    assign w_used     = {1'b0, w_out_cnt} + {1'b0, w_buf_cnt};
    assign w_req      = !rst && !jump_en && (w_used < LIMIT)
                        && !w_tag_full && !w_buf_full;
    assign w_grant    = w_req && imem.imem_gnt;
    assign w_drop     = (r_discard != '0);
    assign w_accept   = imem.imem_rvalid && !jump_en && !w_drop
                        && !w_tag_empty;
    assign w_bypass   = w_accept && !stall_in && w_buf_empty;
    assign w_buf_push = w_accept && !w_bypass;
    assign w_buf_pop  = !jump_en && !stall_in && !w_buf_empty;
    assign w_resp     = '{inst: imem.imem_rdata, pc_addr: w_tag};

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign if_inst        = r_out.inst;
    assign if_pc_addr     = r_out.pc_addr;
    assign if_valid       = r_valid;

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_pop   (w_accept),
        .i_flush (jump_en),
        .i_wdata (r_pc),
        .o_rdata (w_tag),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_out_cnt)
    );

    fetch_fifo #(.WIDTH($bits(fetch_pair_t)), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_buf_push),
        .i_pop   (w_buf_pop),
        .i_flush (jump_en),
        .i_wdata (w_resp),
        .o_rdata (w_buf_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_cnt)
    );

    // PC advances per grant and is redirected by a jump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (jump_en) begin
            r_pc <= jump_addr;
        end else if (w_grant) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Count stale responses still owed by memory after a jump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard <= '0;
        end else if (jump_en) begin
            r_discard <= r_discard + DW'(w_out_cnt)
                         - DW'(imem.imem_rvalid);
        end else if (imem.imem_rvalid && w_drop) begin
            r_discard <= r_discard - DW'(1);
        end
    end

    // IF/ID-facing pair: buffer head first, then bypass, else NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '{inst: NOP_INST, pc_addr: '0};
            r_valid <= 1'b0;
        end else if (jump_en) begin
            r_out   <= '{inst: NOP_INST, pc_addr: '0};
            r_valid <= 1'b0;
        end else if (!stall_in) begin
            if (!w_buf_empty) begin
                r_out   <= w_buf_head;
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_out   <= w_resp;
                r_valid <= 1'b1;
            end else begin
                r_out   <= '{inst: NOP_INST, pc_addr: '0};
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Randomized scoreboard bench for pc_fetch with an in-order,
// variable-latency instruction memory model.
module tb_pc_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int          D   = 4;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] jump_addr = '0;
    logic [31:0] if_inst;
    logic [31:0] if_pc_addr;
    logic        if_valid;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .stall_in   (stall_in),
        .imem       (bus),
        .if_inst    (if_inst),
        .if_pc_addr (if_pc_addr),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend [$];
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          cyc_n = 0;
    int          last_due = 0;
    int          gnt_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] model_pc = RPC;
    logic        cur_valid = 1'b0;
    logic        cur_req = 1'b0;
    logic        was_rst = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive controls, act as memory, update model.
    task automatic cyc(input logic r, input logic j,
                       input logic [31:0] ja, input logic s);
        mreq_t m;
        int    lat;
        @(negedge clk);
        rst       = r;
        jump_en   = j;
        jump_addr = ja;
        stall_in  = s;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.imem_gnt    = 1'b0;
        #1;
        cur_valid = if_valid;
        cur_req   = bus.imem_req;
        if (r) begin
            check("rst_req", 32'(bus.imem_req), 32'd0);
            check("rst_valid", 32'(if_valid), 32'd0);
            check("rst_inst", if_inst, 32'd0);
            check("rst_pc", if_pc_addr, 32'd0);
            pend.delete();
            exp_q.delete();
            model_pc = RPC;
            last_due = cyc_n;
            was_rst  = 1'b1;
        end else begin
            if (was_rst) begin
                check("post_rst_req", 32'(bus.imem_req), 32'd1);
                check("post_rst_addr", bus.imem_addr, RPC);
                was_rst = 1'b0;
            end
            if (pend.size() > 0 && pend[0].due <= cyc_n) begin
                m = pend.pop_front();
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = m.addr ^ KEY;
            end
            bus.imem_gnt = ($urandom_range(99) < gnt_pct);
            if (j) begin
                check("jump_req", 32'(bus.imem_req), 32'd0);
                exp_q.delete();
                model_pc = ja;
            end
            if (bus.imem_req && bus.imem_gnt) begin
                check("req_addr", bus.imem_addr, model_pc);
                exp_q.push_back(model_pc);
                lat = $urandom_range(lat_hi, lat_lo);
                m.addr = bus.imem_addr;
                m.due  = cyc_n + lat;
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                pend.push_back(m);
                model_pc = model_pc + 32'd4;
            end
        end
        cyc_n++;
    endtask

    logic [31:0] p_inst = '0;
    logic [31:0] p_pc = '0;
    logic        p_v = 1'b0;

    // Monitor: every posedge, pop the scoreboard on a fresh output.
    always @(posedge clk) begin : mon
        logic        r_s, j_s, s_s;
        logic [31:0] e;
        r_s = rst;
        j_s = jump_en;
        s_s = stall_in;
        #1;
        if (r_s || j_s) begin
            check("clr_valid", 32'(if_valid), 32'd0);
            check("clr_inst", if_inst, 32'd0);
            check("clr_pc", if_pc_addr, 32'd0);
        end else if (s_s) begin
            check("hold_valid", 32'(if_valid), 32'(p_v));
            check("hold_inst", if_inst, p_inst);
            check("hold_pc", if_pc_addr, p_pc);
        end else if (if_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h want none",
                         if_pc_addr);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", if_pc_addr, e);
                check("out_inst", if_inst, e ^ KEY);
                n_out++;
            end
        end else begin
            check("nop_inst", if_inst, 32'd0);
            check("nop_pc", if_pc_addr, 32'd0);
        end
        p_v    = if_valid;
        p_inst = if_inst;
        p_pc   = if_pc_addr;
    end

    initial begin : stim
        int          bub;
        int          k;
        logic        s, j;
        logic [31:0] ja;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);

        // zero-wait memory, wraps from FFFF_FFF8 through 0
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        bub = 0;
        repeat (20) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            if (!cur_valid) bub++;
        end
        check("thru_lat1", 32'(bub), 32'd0);

        // 5-cycle stall: request must drop once credit is gone
        repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        check("stall_req_drop", 32'(cur_req), 32'd0);
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);

        // jump with two requests outstanding
        lat_lo = 2;
        lat_hi = 2;
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("jmp_gap1", 32'(cur_valid), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("jmp_gap2", 32'(cur_valid), 32'd0);
        k = 0;
        while (!cur_valid && k < 10) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            k++;
        end
        check("jmp_target", cur_valid ? if_pc_addr : 32'hDEAD_BEEF,
              32'h100);
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);

        // jump and stall in the same cycle
        cyc(1'b0, 1'b1, 32'h200, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);

        // 3-cycle memory latency, no bubbles with DEPTH=4
        lat_lo = 3;
        lat_hi = 3;
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        bub = 0;
        repeat (20) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            if (!cur_valid) bub++;
        end
        check("thru_lat3", 32'(bub), 32'd0);

        // randomized traffic
        lat_lo  = 1;
        lat_hi  = 4;
        gnt_pct = 75;
        repeat (3000) begin
            s  = ($urandom_range(99) < 15);
            j  = ($urandom_range(99) < 3);
            ja = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0
                                          : ($urandom & 32'h0000_FFFC);
            cyc(1'b0, j, ja, s);
        end

        // reset mid-stream with a full response buffer
        lat_lo  = 1;
        lat_hi  = 1;
        gnt_pct = 100;
        repeat (5) cyc(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 32'd0, 1'b0);

        check("progress", 32'(n_out > 500), 32'd1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
